mul24_seq: RTL and testbench
============================

# mul24_seq

Sequential 24×24 shift-and-add multiplier for the 24-bit CPU execute stage. It sits directly downstream of the per-bit multiply cell. It takes the operands issued by the ALU, iterates one partial-product bit per clock, and returns a registered 48-bit product with a start/busy/done handshake. It supports unsigned and two's-complement operands and flags results that do not fit in 24 bits.

## Interface
- WIDTH, 24, operand width; product is 2×WIDTH bits.
- Clock  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled only in IDLE.
- Signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with Start.
- A  input  WIDTH  multiplicand; sampled with Start.
- B  input  WIDTH  multiplier; sampled with Start.
- Busy  output  1  high in RUN and DONE.
- Done  output  1  high for exactly one cycle (DONE state).
- ProductHi  output  WIDTH  upper half of result.
- ProductLo  output  WIDTH  lower half of result.
- Overflow  output  1  result does not fit in WIDTH bits; valid with Done, held after.

## Operation
- States: IDLE → RUN → DONE → IDLE.
- IDLE, Start=1: latch Signed and the operand magnitudes.
  - If Signed, each magnitude is the absolute value of its operand.
  - Record neg = Signed & (A[MSB] ^ B[MSB]).
  - Clear the 2×WIDTH accumulator and the bit counter; go to RUN.
- RUN, one step per cycle:
  - If the multiplier LSB = 1, add the multiplicand to the accumulator upper half with a WIDTH+1-bit carry.
  - Shift the accumulator and carry right 1; shift the multiplier right 1; increment the counter.
  - After WIDTH steps, go to DONE.
- DONE:
  - Result = neg ? two's-complement negate of the accumulator : accumulator. Register it to ProductHi/ProductLo.
  - Overflow (unsigned): ProductHi ≠ 0.
  - Overflow (signed): ProductHi ≠ {WIDTH{ProductLo[MSB]}}.
  - Done=1; next state IDLE.
- Magnitude of −2^23 is 0x800000 and fits the unsigned datapath; no special case.
- Start while Busy (RUN or DONE) is ignored; A, B and Signed are not re-sampled.
- ProductHi, ProductLo and Overflow hold their last value until the next DONE.
- A zero operand still takes full latency; there is no early termination.

## Timing
- Reset values: state IDLE, Busy=0, Done=0, ProductHi=0, ProductLo=0, Overflow=0, internal registers 0.
- Reset asserted at any time, including mid-RUN:
  - Immediately returns to the reset values and aborts the operation.
  - No Done is produced for the aborted request.
- Start sampled at edge 0: Busy=1 from edge 0.
- RUN steps occur at edges 1..WIDTH (1..24).
- Edge WIDTH+1 (25): enter DONE; Done=1 and the result is valid in the cycle following edge 25.
- Edge 26: IDLE, Busy=0, Done=0. The earliest next Start is sampled at edge 26.
- Latency is Start to Done = WIDTH+1 edges. Throughput is one product per WIDTH+2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Unsigned 0x000003 × 0x000005 → Done after edge 25; Hi=0x000000, Lo=0x00000F, Overflow=0; Busy drops after edge 26.
- Unsigned 0xFFFFFF × 0xFFFFFF → Hi=0xFFFFFE, Lo=0x000001, Overflow=1.
- Signed 0xFFFFFD (−3) × 0x000007 → Hi=0xFFFFFF, Lo=0xFFFFEB (−21), Overflow=0.
- Signed 0x800000 × 0x800000 → Hi=0x400000, Lo=0x000000, Overflow=1.
- Start with 2×3, then Start re-pulsed with 9×9 at cycle 10 → ignored; result Lo=0x000006 with a single Done pulse.
- Reset_n low at RUN cycle 10 → Busy, Done and outputs are 0 immediately with no Done. Release, then Start 0x000000 × 0xABCDEF → Hi=Lo=0, Overflow=0, Done still after edge 25.

Source files
------------

// File: rtl/mul24_seq_if.sv
// Operand/result bundle between the ALU issue logic and the sequential multiplier.
// The master side drives a request, and the slave side returns the busy/done status and the registered product.
interface mul24_seq_if #(
  parameter int WIDTH = 24
);
  logic             Start;
  logic             Signed;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] ProductHi;
  logic [WIDTH-1:0] ProductLo;
  logic             Overflow;

  // Handshake: Start is accepted only while Busy is low. The operands are
  // captured on that edge. Done then pulses for one cycle, WIDTH+1 edges later.
  // The product and overflow flag stay valid from Done until the next Done.
  modport master (
    output Start, Signed, A, B,
    input  Busy, Done, ProductHi, ProductLo, Overflow
  );

  modport slave (
    input  Start, Signed, A, B,
    output Busy, Done, ProductHi, ProductLo, Overflow
  );
endinterface

// File: rtl/mul24_seq.sv
// Sequential shift-and-add multiplier that produces one partial-product bit per clock.
// It handles unsigned or two's-complement operands by multiplying magnitudes and then fixing the sign.
module mul24_seq #(
  parameter int WIDTH = 24
) (
  input  logic        Clock,
  input  logic        Reset_n,
  mul24_seq_if.slave  bus,
  output logic [1:0]  state_dbg
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      cnt;
   logic               neg;
   logic               sgn;

   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               ovf_q, busy_q, done_q;

   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] res;
   logic               res_ovf;
   logic               steps_done;

   assign steps_done = (cnt == CW'(WIDTH));

   // The magnitude of the most negative value is its own bit pattern, and it fits the unsigned datapath.
   always_comb begin
      a_mag = bus.A;
      b_mag = bus.B;
      if (bus.Signed && bus.A[WIDTH-1]) a_mag = ~bus.A + WIDTH'(1);
      if (bus.Signed && bus.B[WIDTH-1]) b_mag = ~bus.B + WIDTH'(1);
   end

   always_comb begin
      sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
      if (mplier[0]) sum = sum + {1'b0, mcand};
   end

   always_comb begin
      res     = neg ? (~acc + (2*WIDTH)'(1)) : acc;
      res_ovf = sgn ? (res[2*WIDTH-1:WIDTH] != {WIDTH{res[WIDTH-1]}})
                    : (res[2*WIDTH-1:WIDTH] != '0);
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.Start) state_nxt = S_RUN;
         S_RUN:   if (steps_done) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         neg    <= 1'b0;
         sgn    <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
         ovf_q  <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         busy_q <= (state_nxt != S_IDLE);
         done_q <= (state_nxt == S_DONE);
         case (state)
            S_IDLE: begin
               if (bus.Start) begin
                  mcand  <= a_mag;
                  mplier <= b_mag;
                  neg    <= bus.Signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                  sgn    <= bus.Signed;
                  acc    <= '0;
                  cnt    <= '0;
               end
            end
            S_RUN: begin
               if (!steps_done) begin
                  // The carry bit from the upper-half add shifts into the accumulator MSB.
                  acc    <= {sum, acc[WIDTH-1:1]};
                  mplier <= mplier >> 1;
                  cnt    <= cnt + CW'(1);
               end else begin
                  hi_q  <= res[2*WIDTH-1:WIDTH];
                  lo_q  <= res[WIDTH-1:0];
                  ovf_q <= res_ovf;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.Busy      = busy_q;
   assign bus.Done      = done_q;
   assign bus.ProductHi = hi_q;
   assign bus.ProductLo = lo_q;
   assign bus.Overflow  = ovf_q;
   assign state_dbg     = state;

endmodule

// File: tb/tb_mul24_seq.sv
// Bench for mul24_seq: it applies table vectors, random operands against an arithmetic model,
// and hand-written sequences for the Start-while-busy and reset-mid-run cases.
module tb_mul24_seq;

  localparam int W = 24;

  logic       Clock;
  logic       Reset_n;
  logic [1:0] state_dbg;
  int         tests;
  int         fails;

  mul24_seq_if #(.WIDTH(W)) bus ();

  mul24_seq #(.WIDTH(W)) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    bit          sgn;
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] hi;
    logic [23:0] lo;
    bit          ovf;
  } vec_t;

  logic [48:0] exp_q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a plain integer product, with overflow taken as "outside the 24-bit range".
  function automatic logic [48:0] model(input bit s, input logic [23:0] a, input logic [23:0] b);
    longint pa, pb, p;
    bit ov;
    pa = longint'({40'd0, a});
    pb = longint'({40'd0, b});
    if (s && a[23]) pa = pa - 64'sd16777216;
    if (s && b[23]) pb = pb - 64'sd16777216;
    p = pa * pb;
    if (s) ov = (p < -64'sd8388608) || (p > 64'sd8388607);
    else   ov = (p > 64'sd16777215);
    return {ov, p[47:0]};
  endfunction

  // driver tasks
  task automatic start_pulse(input bit s, input logic [23:0] a, input logic [23:0] b);
    @(negedge Clock);
    bus.Start  = 1'b1;
    bus.Signed = s;
    bus.A      = a;
    bus.B      = b;
    @(negedge Clock);
    bus.Start  = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic [23:0] hi, output logic [23:0] lo,
                           output logic ovf);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge Clock);
      if (bus.Done) begin
        lat = i;
        break;
      end
    end
    hi  = bus.ProductHi;
    lo  = bus.ProductLo;
    ovf = bus.Overflow;
  endtask

  task automatic do_op(input string nm, input bit s, input logic [23:0] a, input logic [23:0] b,
                       output logic [23:0] hi, output logic [23:0] lo, output logic ovf,
                       output int lat);
    start_pulse(s, a, b);
    check({nm, " busy after start"}, 64'(bus.Busy), 64'd1);
    wait_done(lat, hi, lo, ovf);
    check({nm, " latency"}, 64'(lat), 64'd25);
    @(negedge Clock);
    check({nm, " busy after done"}, 64'(bus.Busy), 64'd0);
    check({nm, " done one cycle"}, 64'(bus.Done), 64'd0);
  endtask

  initial begin
    vec_t        vt[4];
    logic [23:0] hi, lo;
    logic        ovf;
    int          lat, dones, first_done;
    logic [48:0] e;
    logic [23:0] corner[6];
    bit          s;
    logic [23:0] a, b;

    tests = 0;
    fails = 0;
    vt[0] = '{sgn: 1'b0, a: 24'h000003, b: 24'h000005, hi: 24'h000000, lo: 24'h00000F, ovf: 1'b0};
    vt[1] = '{sgn: 1'b0, a: 24'hFFFFFF, b: 24'hFFFFFF, hi: 24'hFFFFFE, lo: 24'h000001, ovf: 1'b1};
    vt[2] = '{sgn: 1'b1, a: 24'hFFFFFD, b: 24'h000007, hi: 24'hFFFFFF, lo: 24'hFFFFEB, ovf: 1'b0};
    vt[3] = '{sgn: 1'b1, a: 24'h800000, b: 24'h800000, hi: 24'h400000, lo: 24'h000000, ovf: 1'b1};
    corner = '{24'h000000, 24'h000001, 24'h7FFFFF, 24'h800000, 24'hFFFFFF, 24'h800001};

    bus.Start  = 1'b0;
    bus.Signed = 1'b0;
    bus.A      = '0;
    bus.B      = '0;
    Reset_n    = 1'b0;
    repeat (3) @(negedge Clock);
    check("reset busy",  64'(bus.Busy), 64'd0);
    check("reset done",  64'(bus.Done), 64'd0);
    check("reset hi",    64'(bus.ProductHi), 64'd0);
    check("reset lo",    64'(bus.ProductLo), 64'd0);
    check("reset ovf",   64'(bus.Overflow), 64'd0);
    check("reset state", 64'(state_dbg), 64'd0);
    Reset_n = 1'b1;

    // table vectors
    for (int i = 0; i < 4; i++) begin
      do_op($sformatf("vec%0d", i), vt[i].sgn, vt[i].a, vt[i].b, hi, lo, ovf, lat);
      check($sformatf("vec%0d hi", i), 64'(hi), 64'(vt[i].hi));
      check($sformatf("vec%0d lo", i), 64'(lo), 64'(vt[i].lo));
      check($sformatf("vec%0d ovf", i), 64'(ovf), 64'(vt[i].ovf));
    end

    // random operands, with corner values mixed in
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 24'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 24'($urandom);
      exp_q.push_back(model(s, a, b));
      do_op($sformatf("rnd%0d", i), s, a, b, hi, lo, ovf, lat);
      e = exp_q.pop_front();
      check($sformatf("rnd%0d s=%0d %h*%h prod", i, s, a, b), 64'({hi, lo}), 64'(e[47:0]));
      check($sformatf("rnd%0d s=%0d %h*%h ovf", i, s, a, b), 64'(ovf), 64'(e[48]));
    end

    // Start re-pulsed mid-run must be ignored
    start_pulse(1'b0, 24'd2, 24'd3);
    dones = 0;
    first_done = -1;
    for (int i = 1; i <= 45; i++) begin
      @(negedge Clock);
      if (bus.Done) begin
        dones++;
        if (first_done < 0) begin
          first_done = i;
          hi = bus.ProductHi;
          lo = bus.ProductLo;
        end
      end
      bus.Start = (i == 9);
      bus.A     = (i == 9) ? 24'd9 : 24'd2;
      bus.B     = (i == 9) ? 24'd9 : 24'd3;
    end
    bus.Start = 1'b0;
    check("restart done count", 64'(dones), 64'd1);
    check("restart latency", 64'(first_done), 64'd25);
    check("restart hi", 64'(hi), 64'd0);
    check("restart lo", 64'(lo), 64'd6);

    // asynchronous reset mid-run
    start_pulse(1'b0, 24'd5, 24'd7);
    repeat (9) @(negedge Clock);
    check("pre-reset busy", 64'(bus.Busy), 64'd1);
    #2 Reset_n = 1'b0;
    #1;
    check("abort busy", 64'(bus.Busy), 64'd0);
    check("abort done", 64'(bus.Done), 64'd0);
    check("abort hi",   64'(bus.ProductHi), 64'd0);
    check("abort lo",   64'(bus.ProductLo), 64'd0);
    check("abort ovf",  64'(bus.Overflow), 64'd0);
    @(negedge Clock);
    Reset_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clock);
      if (bus.Done || bus.Busy) dones++;
    end
    check("abort no done", 64'(dones), 64'd0);
    do_op("zero op", 1'b0, 24'h000000, 24'hABCDEF, hi, lo, ovf, lat);
    check("zero hi",  64'(hi), 64'd0);
    check("zero lo",  64'(lo), 64'd0);
    check("zero ovf", 64'(ovf), 64'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
